// File: rtl/unary_sum_collector.sv
// Rebuilds each add/drain frame total of the mod-BASE unary adder as carries*BASE + digit
// and presents it on a valid/ready port that overwrites (and flags) unaccepted results.
module unary_sum_collector #(
   parameter int unsigned BASE = 7,
   parameter int unsigned CW   = 8,
   parameter int unsigned OW   = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          read_or_write,
   input  logic          din,
   input  logic          carry_in,
   input  logic          out_ready,
   output logic [OW-1:0] sum_out,
   output logic          sum_valid,
   output logic          sum_sat,
   output logic          overrun,
   output logic          proto_err
);

   localparam int unsigned   DW        = 3;
   localparam logic [CW-1:0] CARRY_MAX = '1;
   localparam logic [DW-1:0] DIGIT_MAX = DW'(BASE - 1);

   typedef enum logic [1:0] {ACCUM, DRAIN, TAIL} state_t;

   state_t        state, state_nx;
   logic          en_d, rw_d;
   logic [CW-1:0] carry_cnt, carry_nx;
   logic [DW-1:0] digit_cnt, digit_nx;
   logic          sat, sat_nx;

   logic          read_slot_c, write_slot_c;
   logic          carry_ovf_c;
   logic [CW-1:0] carry_inc_c;
   logic          publish_c, proto_set_c;
   logic [DW-1:0] pub_digit_c;
   logic [OW-1:0] result_c;

   // Adder outputs lag en/read_or_write by one cycle; slots are judged on the delayed controls.
   assign read_slot_c  = en_d & ~rw_d;
   assign write_slot_c = en_d & rw_d;

   assign carry_ovf_c = carry_in & (carry_cnt == CARRY_MAX);
   assign carry_inc_c = carry_ovf_c ? carry_cnt : carry_cnt + CW'(carry_in);
   assign result_c    = OW'(carry_cnt) * OW'(BASE) + OW'(pub_digit_c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACCUM;
      else        state <= state_nx;
   end

   // Next state, counter updates and publish decision.
   always_comb begin
      state_nx    = state;
      carry_nx    = carry_cnt;
      digit_nx    = digit_cnt;
      sat_nx      = sat;
      publish_c   = 1'b0;
      proto_set_c = 1'b0;
      pub_digit_c = digit_cnt;
      unique case (state)
         ACCUM: begin
            if (read_slot_c) begin
               carry_nx = carry_inc_c;
               sat_nx   = sat | carry_ovf_c;
            end else if (write_slot_c) begin
               if (din) begin
                  digit_nx = DW'(1);
                  state_nx = DRAIN;
               end else begin
                  publish_c   = 1'b1;
                  pub_digit_c = '0;
                  state_nx    = TAIL;
               end
            end
         end
         DRAIN: begin
            if (write_slot_c) begin
               if (din) begin
                  if (digit_cnt == DIGIT_MAX) proto_set_c = 1'b1;
                  else                        digit_nx    = digit_cnt + DW'(1);
               end else begin
                  publish_c = 1'b1;
                  state_nx  = TAIL;
               end
            end else if (read_slot_c) begin
               publish_c = 1'b1;
               state_nx  = ACCUM;
            end
         end
         TAIL: begin
            if (read_slot_c) state_nx = ACCUM;
         end
         default: state_nx = ACCUM;
      endcase
      if (publish_c) begin
         digit_nx = '0;
         sat_nx   = 1'b0;
         carry_nx = '0;
      end
      // A read slot that leaves DRAIN/TAIL carries the first pulse of the next frame.
      if (read_slot_c && state != ACCUM) carry_nx = CW'(carry_in);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_d      <= 1'b0;
         rw_d      <= 1'b0;
         carry_cnt <= '0;
         digit_cnt <= '0;
         sat       <= 1'b0;
         sum_out   <= '0;
         sum_valid <= 1'b0;
         sum_sat   <= 1'b0;
         overrun   <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         en_d      <= en;
         rw_d      <= read_or_write;
         carry_cnt <= carry_nx;
         digit_cnt <= digit_nx;
         sat       <= sat_nx;
         if (proto_set_c) proto_err <= 1'b1;
         // A new result always wins over a same-cycle accept of the old one.
         if (publish_c) begin
            sum_out   <= result_c;
            sum_sat   <= sat;
            sum_valid <= 1'b1;
            if (sum_valid && !out_ready) overrun <= 1'b1;
         end else if (sum_valid && out_ready) begin
            sum_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_unary_sum_collector.sv
// Directed bench for unary_sum_collector: frame-level model checked every cycle plus literal expectations.
module tb_unary_sum_collector;

   localparam int unsigned BASE = 7;
   localparam int unsigned CW   = 8;
   localparam int unsigned OW   = 11;
   localparam int          CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          read_or_write = 1'b0;
   logic          din = 1'b0;
   logic          carry_in = 1'b0;
   logic          out_ready = 1'b0;
   logic [OW-1:0] sum_out;
   logic          sum_valid, sum_sat, overrun, proto_err;

   int checks = 0;
   int failures = 0;

   // Frame-level model: carries and ones are unbounded integers, clipped only when a total is formed.
   int m_carries, m_ones;
   bit m_closed, m_en_d, m_rw_d;
   int e_sum;
   bit e_valid, e_sat, e_overrun, e_proto;
   // Adder output for the slot driven last cycle.
   bit pend_d, pend_c;

   always #5 clk = ~clk;

   unary_sum_collector #(.BASE(BASE), .CW(CW), .OW(OW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .read_or_write(read_or_write), .din(din),
      .carry_in(carry_in), .out_ready(out_ready), .sum_out(sum_out), .sum_valid(sum_valid),
      .sum_sat(sum_sat), .overrun(overrun), .proto_err(proto_err)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_carries = 0; m_ones = 0; m_closed = 0; m_en_d = 0; m_rw_d = 0;
      e_sum = 0; e_valid = 0; e_sat = 0; e_overrun = 0; e_proto = 0;
      pend_d = 0; pend_c = 0;
   endtask

   task automatic frame_total(output int pv, output bit ps);
      pv = ((m_carries > CMAX) ? CMAX : m_carries) * int'(BASE)
         + ((m_ones > int'(BASE) - 1) ? int'(BASE) - 1 : m_ones);
      ps = (m_carries > CMAX);
      m_carries = 0;
      m_ones = 0;
   endtask

   // Frame rules: a zero in a write phase or a return to reading ends a frame; trailing zeros are ignored.
   task automatic model_edge();
      bit pub = 0;
      int pv = 0;
      bit ps = 0;
      if (m_en_d && !m_rw_d) begin
         if (!m_closed && m_ones > 0) begin
            pub = 1;
            frame_total(pv, ps);
         end
         m_closed = 0;
         m_carries += int'(carry_in);
      end else if (m_en_d && m_rw_d && !m_closed) begin
         if (din) begin
            m_ones++;
            if (m_ones > int'(BASE) - 1) e_proto = 1;
         end else begin
            pub = 1;
            frame_total(pv, ps);
            m_closed = 1;
         end
      end
      if (pub) begin
         if (e_valid && !out_ready) e_overrun = 1;
         e_valid = 1;
         e_sum   = pv;
         e_sat   = ps;
      end else if (e_valid && out_ready) begin
         e_valid = 0;
      end
      m_en_d = en;
      m_rw_d = read_or_write;
   endtask

   task automatic compare_cycle();
      check("sum_valid", int'(sum_valid), int'(e_valid));
      check("overrun", int'(overrun), int'(e_overrun));
      check("proto_err", int'(proto_err), int'(e_proto));
      if (e_valid) begin
         check("sum_out", int'(sum_out), e_sum);
         check("sum_sat", int'(sum_sat), int'(e_sat));
      end
   endtask

   // One cycle: d/c are the adder's dout/C for this slot, which reach the DUT a cycle later.
   task automatic step(input bit e, input bit rw, input bit d, input bit c);
      en = e;
      read_or_write = rw;
      din = pend_d;
      carry_in = pend_c;
      pend_d = d;
      pend_c = c;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_cycle();
      #1;
   endtask

   task automatic reads(input int n, input bit c);
      for (int i = 0; i < n; i++) step(1, 0, 0, c);
   endtask

   task automatic writes(input int n, input bit d);
      for (int i = 0; i < n; i++) step(1, 1, d, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic accept();
      out_ready = 1;
      idle(1);
      out_ready = 0;
   endtask

   task automatic expect_out(input string name, input int sum, input bit valid);
      check({name, "_sum"}, int'(sum_out), sum);
      check({name, "_valid"}, int'(sum_valid), int'(valid));
   endtask

   task automatic expect_flags(input string name, input bit sat, input bit ovr, input bit perr);
      check({name, "_sat"}, int'(sum_sat), int'(sat));
      check({name, "_overrun"}, int'(overrun), int'(ovr));
      check({name, "_proto"}, int'(proto_err), int'(perr));
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      expect_out("reset", 0, 0);
      expect_flags("reset", 0, 0, 0);
      #1 rst_n = 1;

      // 1*7+1: four add cycles with one carry, then a drain of a single one.
      reads(3, 0); reads(1, 1);
      writes(1, 1); writes(7, 0);
      idle(2);
      expect_out("frame8", 8, 1);
      expect_flags("frame8", 0, 0, 0);
      accept();
      check("frame8_accepted", int'(sum_valid), 0);

      // Three ones, trailing zeros swallowed.
      reads(3, 0);
      writes(3, 1); writes(2, 0);
      idle(2);
      expect_out("frame3", 3, 1);
      accept();

      // Empty frame.
      reads(1, 0);
      writes(2, 0);
      idle(2);
      expect_out("empty", 0, 1);
      accept();

      // Back-to-back publishes (1 then 7) with out_ready held high.
      out_ready = 1;
      reads(1, 0);
      writes(1, 1);
      reads(1, 1);
      writes(1, 0);
      idle(1);
      expect_out("same_cycle", 7, 1);
      check("same_cycle_overrun", int'(overrun), 0);
      idle(1);
      check("same_cycle_drained", int'(sum_valid), 0);
      out_ready = 0;

      // en low mid-drain with dout held: 2*7+3.
      reads(1, 0); reads(2, 1);
      writes(2, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
      writes(1, 1); writes(1, 0);
      idle(2);
      expect_out("en_gap", 17, 1);
      accept();

      // Carry counter saturation: 260 pulses clip to 255.
      reads(260, 1);
      writes(2, 1); writes(1, 0);
      idle(2);
      expect_out("saturate", 255 * 7 + 2, 1);
      check("saturate_sat", int'(sum_sat), 1);
      accept();

      // Two unaccepted frames: the second overwrites and overrun sticks.
      reads(3, 0); reads(1, 1);
      writes(1, 1); writes(7, 0);
      reads(3, 0);
      writes(3, 1); writes(2, 0);
      idle(2);
      expect_out("overwrite", 3, 1);
      expect_flags("overwrite", 0, 1, 0);
      accept();
      check("overrun_sticky", int'(overrun), 1);

      // Eight ones in one drain: digit clips at 6 and proto_err sets.
      reads(1, 0);
      writes(8, 1); writes(1, 0);
      idle(2);
      expect_out("proto", 6, 1);
      check("proto_flag", int'(proto_err), 1);
      accept();

      // Asynchronous reset in the middle of a drain.
      reads(1, 1);
      writes(2, 1);
      rst_n = 0;
      en = 0; read_or_write = 0; din = 0; carry_in = 0;
      #1;
      expect_out("midreset", 0, 0);
      expect_flags("midreset", 0, 0, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      #1;
      reads(1, 1);
      writes(2, 1); writes(1, 0);
      idle(2);
      expect_out("post_reset", 9, 1);
      expect_flags("post_reset", 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
